bg_fetch_sched: RTL and testbench

BG_FETCH_SCHED -- requirements
Module: bg_fetch_sched

---
 rtl/ppu_pkg.sv | 39 +++
 rtl/bg_fetch_table.sv | 133 +++++++++++++
 rtl/bg_fetch_sched.sv | 99 +++++++++
 tb/tb_bg_fetch_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// PPU shared types for the background fetch scheduler.
// Slot entries, BG format codes and line-length constants.
package ppu_pkg;

    typedef struct packed {
        logic [1:0] owner;
        logic       is_map;
        logic       is_data;
        logic [2:0] num;
    } slot_ent_t;

    localparam logic [8:0] FETCH_X_LAST = 9'd263;
    localparam logic [2:0] MODE_IDLE    = 3'd7;

    localparam logic [2:0] FMT_OPT      = 3'b000;
    localparam logic [2:0] FMT_2BPP     = 3'b001;
    localparam logic [2:0] FMT_4BPP     = 3'b010;
    localparam logic [2:0] FMT_8BPP     = 3'b011;
    localparam logic [2:0] FMT_OPT4     = 3'b100;
    localparam logic [2:0] FMT_2BPP_HI  = 3'b101;
    localparam logic [2:0] FMT_4BPP_HI  = 3'b110;

    localparam slot_ent_t ENT_IDLE = '0;

    function automatic slot_ent_t ent_m(input logic [1:0] bg,
                                        input logic [2:0] n);
        slot_ent_t e;
        e = '{owner: bg, is_map: 1'b1, is_data: 1'b0, num: n};
        return e;
    endfunction

    function automatic slot_ent_t ent_d(input logic [1:0] bg,
                                        input logic [2:0] n);
        slot_ent_t e;
        e = '{owner: bg, is_map: 1'b0, is_data: 1'b1, num: n};
        return e;
    endfunction

endpackage

// File: rtl/bg_fetch_table.sv
// Combinational mode/slot lookup for the BG fetch scheduler.
// Gives the slot owner/kind/num plus per-BG format and enable.
module bg_fetch_table
    import ppu_pkg::*;
(
    input  logic [2:0]       mode,
    input  logic [2:0]       slot,
    output slot_ent_t        ent,
    output logic [3:0][2:0]  fmt,
    output logic [3:0]       en
);

    // Slot schedule and BG formats for the selected mode
    always_comb begin
        ent = ENT_IDLE;
        fmt = '0;
        en  = '0;
        unique case (mode)
            3'd0: begin
                fmt[0] = FMT_2BPP;
                fmt[1] = FMT_2BPP;
                fmt[2] = FMT_2BPP;
                fmt[3] = FMT_2BPP;
                en     = 4'b1111;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_m(2'd2, 3'd0);
                    3'd3: ent = ent_m(2'd3, 3'd0);
                    3'd4: ent = ent_d(2'd0, 3'd0);
                    3'd5: ent = ent_d(2'd1, 3'd0);
                    3'd6: ent = ent_d(2'd2, 3'd0);
                    3'd7: ent = ent_d(2'd3, 3'd0);
                endcase
            end
            3'd1: begin
                fmt[0] = FMT_4BPP;
                fmt[1] = FMT_4BPP;
                fmt[2] = FMT_2BPP;
                en     = 4'b0111;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_m(2'd2, 3'd0);
                    3'd3: ent = ent_d(2'd0, 3'd0);
                    3'd4: ent = ent_d(2'd0, 3'd2);
                    3'd5: ent = ent_d(2'd1, 3'd0);
                    3'd6: ent = ent_d(2'd1, 3'd2);
                    3'd7: ent = ent_d(2'd2, 3'd0);
                endcase
            end
            3'd2: begin
                fmt[0] = FMT_4BPP;
                fmt[1] = FMT_4BPP;
                fmt[2] = FMT_OPT;
                en     = 4'b0111;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_m(2'd2, 3'd0);
                    3'd3: ent = ent_m(2'd2, 3'd1);
                    3'd4: ent = ent_d(2'd0, 3'd0);
                    3'd5: ent = ent_d(2'd0, 3'd2);
                    3'd6: ent = ent_d(2'd1, 3'd0);
                    3'd7: ent = ent_d(2'd1, 3'd2);
                endcase
            end
            3'd3: begin
                fmt[0] = FMT_8BPP;
                fmt[1] = FMT_4BPP;
                en     = 4'b0011;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_d(2'd0, 3'd0);
                    3'd3: ent = ent_d(2'd0, 3'd2);
                    3'd4: ent = ent_d(2'd0, 3'd4);
                    3'd5: ent = ent_d(2'd0, 3'd6);
                    3'd6: ent = ent_d(2'd1, 3'd0);
                    3'd7: ent = ent_d(2'd1, 3'd2);
                endcase
            end
            3'd4: begin
                fmt[0] = FMT_8BPP;
                fmt[1] = FMT_2BPP;
                fmt[2] = FMT_OPT4;
                en     = 4'b0111;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_m(2'd2, 3'd0);
                    3'd3: ent = ent_d(2'd0, 3'd0);
                    3'd4: ent = ent_d(2'd0, 3'd2);
                    3'd5: ent = ent_d(2'd0, 3'd4);
                    3'd6: ent = ent_d(2'd0, 3'd6);
                    3'd7: ent = ent_d(2'd1, 3'd0);
                endcase
            end
            3'd5: begin
                fmt[0] = FMT_4BPP_HI;
                fmt[1] = FMT_2BPP_HI;
                en     = 4'b0011;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd1, 3'd0);
                    3'd2: ent = ent_d(2'd0, 3'd0);
                    3'd3: ent = ent_d(2'd0, 3'd1);
                    3'd4: ent = ent_d(2'd0, 3'd2);
                    3'd5: ent = ent_d(2'd0, 3'd3);
                    3'd6: ent = ent_d(2'd1, 3'd0);
                    3'd7: ent = ent_d(2'd1, 3'd1);
                endcase
            end
            3'd6: begin
                fmt[0] = FMT_4BPP_HI;
                fmt[2] = FMT_OPT;
                en     = 4'b0101;
                unique case (slot)
                    3'd0: ent = ent_m(2'd0, 3'd0);
                    3'd1: ent = ent_m(2'd2, 3'd0);
                    3'd2: ent = ent_m(2'd2, 3'd1);
                    3'd3: ent = ent_d(2'd0, 3'd0);
                    3'd4: ent = ent_d(2'd0, 3'd1);
                    3'd5: ent = ent_d(2'd0, 3'd2);
                    3'd6: ent = ent_d(2'd0, 3'd3);
                    3'd7: ent = ENT_IDLE;
                endcase
            end
            3'd7: ent = ENT_IDLE;
        endcase
    end

endmodule

// File: rtl/bg_fetch_sched.sv
// Background fetch scheduler: walks x across a scanline and
// issues per-BG map/data strobes from the latched mode's slot table.
module bg_fetch_sched
    import ppu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             dot_en,
    input  logic             line_start,
    input  logic [2:0]       bg_mode,
    input  logic [3:0][14:0] bg_vram_addr,
    output logic [8:0]       x,
    output logic [3:0]       fetch_map,
    output logic [3:0]       fetch_data,
    output logic [2:0]       fetch_data_num,
    output logic [3:0][2:0]  bg_fmt,
    output logic [3:0]       bg_en,
    output logic [14:0]      vram_addr,
    output logic             newline,
    output logic             active
);

    logic [8:0] x_q, x_d;
    logic       active_q, active_d;
    logic       newline_q, newline_d;
    logic [2:0] mode_q, mode_d;

    slot_ent_t  ent;
    logic [3:0] sel;

    // Line sequencing: restart on line_start, else advance to the last dot
    always_comb begin
        x_d       = x_q;
        active_d  = active_q;
        newline_d = newline_q;
        mode_d    = mode_q;
        if (dot_en) begin
            newline_d = 1'b0;
            if (line_start) begin
                mode_d    = bg_mode;
                x_d       = '0;
                active_d  = 1'b1;
                newline_d = 1'b1;
            end else if (active_q) begin
                if (x_q == FETCH_X_LAST) begin
                    active_d = 1'b0;
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
        end
    end

    // State registers; reset parks the latched mode on the idle mode
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            active_q  <= 1'b0;
            newline_q <= 1'b0;
            mode_q    <= MODE_IDLE;
        end else begin
            x_q       <= x_d;
            active_q  <= active_d;
            newline_q <= newline_d;
            mode_q    <= mode_d;
        end
    end

    bg_fetch_table u_table (
        .mode (mode_q),
        .slot (x_q[2:0]),
        .ent  (ent),
        .fmt  (bg_fmt),
        .en   (bg_en)
    );

    // Strobes and address of the slot owner, gated by active
    always_comb begin
        fetch_map      = '0;
        fetch_data     = '0;
        fetch_data_num = '0;
        sel            = '0;
        vram_addr      = '0;
        if (active_q && (ent.is_map || ent.is_data)) begin
            sel[ent.owner]  = 1'b1;
            fetch_data_num  = ent.num;
        end
        if (ent.is_map) fetch_map = sel;
        if (ent.is_data) fetch_data = sel;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) vram_addr = vram_addr | bg_vram_addr[i];
        end
    end

    assign x       = x_q;
    assign active  = active_q;
    assign newline = newline_q;

endmodule

// File: tb/tb_bg_fetch_sched.sv
// Scoreboard bench for bg_fetch_sched: driver pushes model predictions,
// a negedge monitor pops and compares against the DUT outputs.
module tb_bg_fetch_sched;

    logic             clk;
    logic             reset;
    logic             dot_en;
    logic             line_start;
    logic [2:0]       bg_mode;
    logic [3:0][14:0] va;
    logic [8:0]       d_x;
    logic [3:0]       d_map;
    logic [3:0]       d_data;
    logic [2:0]       d_num;
    logic [3:0][2:0]  d_fmt;
    logic [3:0]       d_en;
    logic [14:0]      d_va;
    logic             d_nl;
    logic             d_act;

    bg_fetch_sched dut (
        .clk            (clk),
        .reset          (reset),
        .dot_en         (dot_en),
        .line_start     (line_start),
        .bg_mode        (bg_mode),
        .bg_vram_addr   (va),
        .x              (d_x),
        .fetch_map      (d_map),
        .fetch_data     (d_data),
        .fetch_data_num (d_num),
        .bg_fmt         (d_fmt),
        .bg_en          (d_en),
        .vram_addr      (d_va),
        .newline        (d_nl),
        .active         (d_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x;
        logic        act;
        logic        nl;
        logic [3:0]  mp;
        logic [3:0]  dt;
        logic [2:0]  nm;
        logic [11:0] fmt;
        logic [3:0]  en;
        logic [14:0] va;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Slot tables, 4 chars per slot: kind, BG number, '/', num
    string slot_tab [8] = '{
        "M1  M2  M3  M4  D1  D2  D3  D4  ",
        "M1  M2  M3  D1/0D1/2D2/0D2/2D3  ",
        "M1  M2  M3/0M3/1D1/0D1/2D2/0D2/2",
        "M1  M2  D1/0D1/2D1/4D1/6D2/0D2/2",
        "M1  M2  M3  D1/0D1/2D1/4D1/6D2  ",
        "M1  M2  D1/0D1/1D1/2D1/3D2/0D2/1",
        "M1  M3/0M3/1D1/0D1/1D1/2D1/3--  ",
        "--  --  --  --  --  --  --  --  "
    };

    // BG1..BG4 formats, 4 chars per BG; '-' means not enabled
    string fmt_tab [8] = '{
        "001 001 001 001 ",
        "010 010 001 -   ",
        "010 010 000 -   ",
        "011 010 -   -   ",
        "011 001 100 -   ",
        "110 101 -   -   ",
        "110 -   000 -   ",
        "-   -   -   -   "
    };

    int m_x;
    bit m_act;
    bit m_nl;
    int m_mode;

    function automatic exp_t predict();
        exp_t  e;
        string row;
        string fr;
        byte   k;
        int    s;
        int    b;
        e.x   = m_x[8:0];
        e.act = m_act;
        e.nl  = m_nl;
        e.mp  = '0;
        e.dt  = '0;
        e.nm  = '0;
        e.va  = '0;
        e.fmt = '0;
        e.en  = '0;
        if (m_act) begin
            row = slot_tab[m_mode];
            s   = m_x % 8;
            k   = row.getc(4 * s);
            if (k != "-") begin
                b = row.getc(4 * s + 1) - "1";
                if (row.getc(4 * s + 2) == "/")
                    e.nm = 3'(row.getc(4 * s + 3) - "0");
                if (k == "M") e.mp[b] = 1'b1;
                else          e.dt[b] = 1'b1;
                e.va = va[b];
            end
        end
        fr = fmt_tab[m_mode];
        for (int i = 0; i < 4; i++) begin
            if (fr.getc(4 * i) != "-") begin
                e.en[i] = 1'b1;
                for (int j = 0; j < 3; j++)
                    e.fmt[3 * i + 2 - j] = (fr.getc(4 * i + j) == "1");
            end
        end
        return e;
    endfunction

    task automatic model_update(input bit rst, input bit de,
                                input bit ls, input int md);
        if (rst) begin
            m_x = 0; m_act = 0; m_nl = 0; m_mode = 7;
        end else if (de) begin
            m_nl = 0;
            if (ls) begin
                m_mode = md; m_x = 0; m_act = 1; m_nl = 1;
            end else if (m_act) begin
                if (m_x == 263) m_act = 0;
                else            m_x = m_x + 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit de,
                        input bit ls, input int md);
        reset      = rst;
        dot_en     = de;
        line_start = ls;
        bg_mode    = 3'(md);
        for (int i = 0; i < 4; i++) va[i] = 15'($urandom);
        q.push_back(predict());
        @(posedge clk);
        model_update(rst, de, ls, md);
        #1;
    endtask

    task automatic dots(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1, 0, int'($urandom_range(0, 7)));
    endtask

    task automatic dots_to(input int tx);
        int guard = 0;
        while (m_x != tx && guard < 300) begin
            step(0, 1, 0, int'($urandom_range(0, 7)));
            guard++;
        end
    endtask

    // Monitor: compare every presented output against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (d_x !== e.x || d_act !== e.act || d_nl !== e.nl ||
                d_map !== e.mp || d_data !== e.dt || d_num !== e.nm ||
                {d_fmt} !== e.fmt || d_en !== e.en || d_va !== e.va) begin
                bad++;
                $display("FAIL outputs cyc=%0d got x=%0d act=%b nl=%b map=%b dat=%b num=%0d fmt=%h en=%b va=%h want x=%0d act=%b nl=%b map=%b dat=%b num=%0d fmt=%h en=%b va=%h",
                         cyc, d_x, d_act, d_nl, d_map, d_data, d_num,
                         {d_fmt}, d_en, d_va, e.x, e.act, e.nl, e.mp,
                         e.dt, e.nm, e.fmt, e.en, e.va);
            end
            total++;
            if ($countones(d_map | d_data) > 1) begin
                bad++;
                $display("FAIL onehot cyc=%0d got map=%b dat=%b want at most one bit",
                         cyc, d_map, d_data);
            end
        end
    end

    initial begin
        int md;
        reset      = 1'b1;
        dot_en     = 1'b0;
        line_start = 1'b0;
        bg_mode    = 3'd0;
        va         = '0;
        @(posedge clk);
        model_update(1, 0, 0, 0);
        #1;
        step(1, 0, 0, 3);
        step(0, 0, 1, 2);
        step(0, 1, 1, 1);
        dots(16);
        step(0, 1, 1, 2);
        dots(8);
        dots_to(263);
        dots(4);
        step(0, 1, 1, 4);
        dots_to(120);
        for (int i = 0; i < 5; i++) step(0, 0, i % 2, 7);
        dots(3);
        dots_to(100);
        step(0, 1, 1, 5);
        dots(10);
        step(0, 1, 1, 6);
        dots_to(50);
        step(1, 0, 0, 0);
        dots(3);
        step(0, 1, 1, 7);
        dots_to(263);
        dots(3);
        step(0, 1, 1, 0);
        dots(40);
        for (int i = 0; i < 4000; i++) begin
            md = int'($urandom_range(0, 7));
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0, md);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
